clk_rst_seq_ctrl: RTL
=====================

Name: clk_rst_seq_ctrl

Overview:
- Reset/clock-enable sequencer for the FANOUT-wide clk_rst bundle.
- After power-on, and after any software request, it holds the selected domains in reset with their clocks gated.
- It then releases the domains one at a time in ascending index order: clock enable first, then reset deassert, then a stagger gap before the next domain.
- Sits between the harness top and the per-domain clock gates and reset drivers.

Parameters:
- FANOUT, 4: number of clk/rst domains; set to the project-wide clk_rst fanout.
- HOLD_CYCLES, 8: cycles the selected resets are held asserted before release begins; must be >= 1.
- CLK_LEAD, 2: cycles clk_en[i] is high before rst_n_out[i] deasserts; must be >= 1.
- STAGGER, 4: cycles after rst_n_out[i] deasserts before the next index is scanned; must be >= 1.

Ports:
- clk  in  1  block clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  sequence request.
- req_mask  in  FANOUT  domains to re-sequence; sampled on accept.
- req_ready  out  1  high only in IDLE.
- rst_n_out  out  FANOUT  per-domain active-low reset.
- clk_en  out  FANOUT  per-domain clock enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a sequence completes.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rst_n_out = 0 and clk_en = 0 on all bits.
  - busy = 1, done = 0.
  - Internal mask = all ones, state = HOLD, counter = 0.
  - A power-on sequence therefore starts on the first edge after rst_n rises.
- States: IDLE, HOLD, SCAN, LEAD, STAG, DONE. All outputs are registered.
- IDLE:
  - req_ready = 1.
  - On an edge with req_valid & req_ready:
    - Latch req_mask.
    - rst_n_out[m] <= 0 and clk_en[m] <= 0 for every set bit m.
    - Unmasked bits are unchanged.
    - Go to HOLD with counter = 0.
  - A request with req_mask == 0 is still accepted: HOLD/SCAN run with no output change, then done pulses.
- HOLD:
  - Counter increments each edge.
  - On the HOLD_CYCLES-th edge after entry, go to SCAN with index i = 0.
- SCAN, one edge per index:
  - If mask[i] = 1: clk_en[i] <= 1, go to LEAD.
  - If mask[i] = 0 and i < FANOUT-1: i <= i+1, stay in SCAN.
  - If mask[i] = 0 and i = FANOUT-1: go to DONE.
- LEAD: on the CLK_LEAD-th edge after entry, rst_n_out[i] <= 1 and go to STAG.
- STAG: on the STAGGER-th edge after entry:
  - If i < FANOUT-1: i <= i+1, go to SCAN.
  - Otherwise go to DONE.
- DONE:
  - done = 1 for exactly one cycle; busy stays 1.
  - Next edge: IDLE, done = 0, busy = 0.
- Counter:
  - Width is $clog2(max(HOLD_CYCLES, CLK_LEAD, STAGGER)+1).
  - Cleared on every state entry; never wraps within a state.
- Index i:
  - Width is $clog2(FANOUT), minimum 1.
  - Never exceeds FANOUT-1.
- Requests while busy are not accepted (req_ready = 0). The requester holds req_valid; there is no queuing.
- Unmasked domains keep their rst_n_out and clk_en values for the whole sequence.
- Ordering invariants:
  - clk_en[i] never rises in the same cycle as rst_n_out[i].
  - At most one domain changes outputs per edge.
- rst_n asserted mid-sequence: all outputs return immediately to reset values, and the power-on all-ones sequence restarts after release.

Test Plan:
- Power-on, FANOUT=4, defaults:
  - Release rst_n at edge 0.
  - clk_en[0] rises at edge 9 and rst_n_out[0] at edge 11.
  - Domain 1: clk_en at 16, rst at 18. Domain 2: 23/25. Domain 3: 30/32.
  - done is high for the single cycle following edge 36; req_ready rises after edge 37.
- Partial request, mask = 0101, accepted at edge 0:
  - Bits 0 and 2 go low at edge 0; bits 1 and 3 stay 1.
  - clk_en[0] at 9, rst_n_out[0] at 11.
  - clk_en[2] at 17, rst_n_out[2] at 19.
  - done follows edge 24.
- Zero mask: accept req_mask = 0 at edge 0 -> no output changes; done follows edge 12 (8 HOLD + 4 SCAN edges).
- Request while busy: drive req_valid with mask 0010 during HOLD -> req_ready = 0 and outputs unaffected. The request is accepted on the first IDLE cycle after done.
- Mid-sequence reset: assert rst_n while in LEAD for domain 2 -> all rst_n_out and clk_en go to 0 asynchronously; after release the power-on timing repeats exactly.
- Parameter sweep, HOLD_CYCLES=1, CLK_LEAD=1, STAGGER=1, FANOUT=2:
  - clk_en[0] at edge 2, rst_n_out[0] at 3.
  - clk_en[1] at 5, rst_n_out[1] at 6.
  - done follows edge 7.

Source files
------------

// File: rtl/clk_rst_seq_ctrl_if.sv
// Request handshake into the clk/rst sequencer: a mask of domains to re-sequence,
// accepted only while the sequencer is idle.
interface clk_rst_seq_ctrl_if #(
  parameter int unsigned FANOUT = 4
);
  logic              req_valid;
  logic [FANOUT-1:0] req_mask;
  logic              req_ready;

  modport master (
    output req_valid,
    output req_mask,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_mask,
    output req_ready
  );
endinterface

// File: rtl/clk_rst_seq_ctrl.sv
// Reset/clock-enable sequencer: holds selected domains in reset with clocks gated, then
// releases them one at a time (clock enable, reset deassert, stagger gap) in index order.
module clk_rst_seq_ctrl #(
  parameter int unsigned FANOUT      = 4,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned CLK_LEAD    = 2,
  parameter int unsigned STAGGER     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  clk_rst_seq_ctrl_if.slave        req,
  output logic [FANOUT-1:0]        rst_n_out,
  output logic [FANOUT-1:0]        clk_en,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned MaxHl  = (HOLD_CYCLES > CLK_LEAD) ? HOLD_CYCLES : CLK_LEAD;
  localparam int unsigned MaxCyc = (MaxHl > STAGGER) ? MaxHl : STAGGER;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);
  localparam int unsigned IdxW   = (FANOUT > 1) ? $clog2(FANOUT) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StHold,
    StScan,
    StLead,
    StStag,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [FANOUT-1:0] mask_q, mask_d;
  logic [FANOUT-1:0] rst_q, rst_d;
  logic [FANOUT-1:0] en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;

  logic last_idx;
  assign last_idx = (idx_q == IdxW'(FANOUT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    idx_d   = idx_q;
    mask_d  = mask_q;
    rst_d   = rst_q;
    en_d    = en_q;

    unique case (state_q)
      StIdle: begin
        if (req.req_valid && ready_q) begin
          mask_d  = req.req_mask;
          rst_d   = rst_q & ~req.req_mask;
          en_d    = en_q & ~req.req_mask;
          state_d = StHold;
        end
      end
      StHold: begin
        if (cnt_q == CntW'(HOLD_CYCLES - 1)) begin
          idx_d   = '0;
          state_d = StScan;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StScan: begin
        if (mask_q[idx_q]) begin
          en_d[idx_q] = 1'b1;
          state_d     = StLead;
        end else if (last_idx) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StLead: begin
        if (cnt_q == CntW'(CLK_LEAD - 1)) begin
          rst_d[idx_q] = 1'b1;
          state_d      = StStag;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStag: begin
        if (cnt_q == CntW'(STAGGER - 1)) begin
          if (last_idx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StScan;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Status flags are registered from the next state so they line up with it.
    ready_d = (state_d == StIdle);
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StHold;
      cnt_q   <= '0;
      idx_q   <= '0;
      mask_q  <= '1;
      rst_q   <= '0;
      en_q    <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      rst_q   <= rst_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign rst_n_out     = rst_q;
  assign clk_en        = en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign req.req_ready = ready_q;

endmodule
